inv_lerp: RTL and testbench

- Inverse of the synth's linear interpolator: given endpoints a, b and a sample v, computes the fixed-point ratio such that lerp(a, b, ratio) ≈ v.
  - Ratio format: QU0.r, r = RATIO_FRAC_BITS.
- Used by envelope and crossfade control paths to recover a position from a level.
- Computed by a multi-cycle restoring divider behind valid/ready handshakes on input and output.

---
 rtl/inv_lerp_pkg.sv | 40 ++++
 rtl/inv_lerp_udiv_step.sv | 24 ++
 rtl/inv_lerp.sv | 129 ++++++++++++
 tb/tb_inv_lerp.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/inv_lerp_pkg.sv
// Shared lerp types: widths, request classification and FSM states.
package inv_lerp_pkg;

    localparam int INPUT_BITS_DEF      = 16;
    localparam int RATIO_FRAC_BITS_DEF = 8;

    typedef logic        [INPUT_BITS_DEF-1:0]      uint_t;
    typedef logic signed [INPUT_BITS_DEF:0]        sint_t;
    typedef logic        [RATIO_FRAC_BITS_DEF-1:0] ratio_t;

    // How a request resolves; only NORMAL uses the divider result.
    typedef enum logic [1:0] {
        NORMAL,
        ZERO,
        CLAMP_LO,
        CLAMP_HI
    } cls_e;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_e;

    // Priority matters: a degenerate span wins over everything,
    // and v == a is exact rather than clamped.
    function automatic cls_e classify(input logic den_zero,
                                      input logic num_zero,
                                      input logic sign_differs,
                                      input logic num_ge_den);
        cls_e c;
        if (den_zero)          c = CLAMP_LO;
        else if (num_zero)     c = ZERO;
        else if (sign_differs) c = CLAMP_LO;
        else if (num_ge_den)   c = CLAMP_HI;
        else                   c = NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/inv_lerp_udiv_step.sv
// One restoring-division iteration: shift the remainder, subtract the
// divisor when it fits, emit the quotient bit.
module udiv_step #(
    parameter int W = 16
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] den,
    output logic [W:0]   rem_next,
    output logic         qbit
);

    logic [W+1:0] rem2;
    logic [W:0]   diff;

    // The caller keeps rem < den, so when the subtraction is taken rem2 is
    // below 2*den and fits in W+1 bits; diff can drop the top bit.
    always_comb begin
        rem2     = {rem, 1'b0};
        qbit     = (rem2 >= {2'b00, den});
        diff     = rem2[W:0] - {1'b0, den};
        rem_next = qbit ? diff : rem2[W:0];
    end

endmodule

// File: rtl/inv_lerp.sv
// Inverse lerp: ratio such that lerp(a, b, ratio) ~= v, computed with a
// fixed-latency MSB-first restoring divider behind valid/ready handshakes.
module inv_lerp
    import inv_lerp_pkg::*;
#(
    parameter int INPUT_BITS      = INPUT_BITS_DEF,
    parameter int RATIO_FRAC_BITS = RATIO_FRAC_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUT_BITS-1:0]      a,
    input  logic [INPUT_BITS-1:0]      b,
    input  logic [INPUT_BITS-1:0]      v,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RATIO_FRAC_BITS-1:0] ratio,
    output logic                       clamped
);

    localparam int CNT_W = (RATIO_FRAC_BITS > 1) ? $clog2(RATIO_FRAC_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RATIO_FRAC_BITS - 1);

    state_e                     state_reg, state_next;
    cls_e                       cls_reg, cls_in;
    logic [CNT_W-1:0]           cnt_reg;
    logic [INPUT_BITS:0]        rem_reg;
    logic [INPUT_BITS-1:0]      den_reg;
    logic [RATIO_FRAC_BITS-2:0] quot_reg;
    logic [RATIO_FRAC_BITS-1:0] quot_next;
    logic [RATIO_FRAC_BITS-1:0] ratio_reg, ratio_next;
    logic                       clamped_reg, clamped_next;

    logic                       num_neg, den_neg;
    logic [INPUT_BITS-1:0]      num_mag, den_mag;
    logic [INPUT_BITS:0]        step_rem;
    logic                       step_q;
    logic                       accept, release_out, last_iter;

    // Signed differences handled as sign + magnitude; |v-a| and |b-a|
    // always fit in INPUT_BITS unsigned.
    always_comb begin
        num_neg = (v < a);
        den_neg = (b < a);
        num_mag = num_neg ? (a - v) : (v - a);
        den_mag = den_neg ? (a - b) : (b - a);
        cls_in  = classify(den_mag == '0, num_mag == '0,
                           num_neg != den_neg, num_mag >= den_mag);
    end

    udiv_step #(.W(INPUT_BITS)) u_step (
        .rem      (rem_reg),
        .den      (den_reg),
        .rem_next (step_rem),
        .qbit     (step_q)
    );

    // Handshakes, next state and the value loaded when the divide finishes.
    always_comb begin
        state_next   = state_reg;
        in_ready     = (state_reg == IDLE);
        out_valid    = (state_reg == DONE);
        accept       = in_valid & in_ready;
        release_out  = out_valid & out_ready;
        last_iter    = (state_reg == DIVIDE) && (cnt_reg == '0);
        quot_next    = {quot_reg, step_q};
        ratio_next   = '0;
        clamped_next = 1'b0;

        case (cls_reg)
            NORMAL:   ratio_next = quot_next;
            ZERO:     ratio_next = '0;
            CLAMP_LO: clamped_next = 1'b1;
            CLAMP_HI: begin
                ratio_next   = '1;
                clamped_next = 1'b1;
            end
            default:  ratio_next = '0;
        endcase

        case (state_reg)
            IDLE:    if (accept)      state_next = DIVIDE;
            DIVIDE:  if (last_iter)   state_next = DONE;
            DONE:    if (release_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Operand latch at accept, one divide iteration per DIVIDE edge,
    // result load on the final iteration and held through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cls_reg     <= NORMAL;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            den_reg     <= '0;
            quot_reg    <= '0;
            ratio_reg   <= '0;
            clamped_reg <= 1'b0;
        end else begin
            if (accept) begin
                cls_reg  <= cls_in;
                cnt_reg  <= CNT_LOAD;
                rem_reg  <= {1'b0, num_mag};
                den_reg  <= den_mag;
                quot_reg <= '0;
            end else if (state_reg == DIVIDE) begin
                rem_reg  <= step_rem;
                quot_reg <= quot_next[RATIO_FRAC_BITS-2:0];
                cnt_reg  <= cnt_reg - CNT_W'(1);
            end
            if (last_iter) begin
                ratio_reg   <= ratio_next;
                clamped_reg <= clamped_next;
            end
        end
    end

    assign ratio   = ratio_reg;
    assign clamped = clamped_reg;

endmodule

// File: tb/tb_inv_lerp.sv
// Scoreboard bench for inv_lerp: directed classes, backpressure, mid-divide
// reset and random requests with a floor-formula model and round-trip check.
module tb_inv_lerp;

    localparam int W = 16;
    localparam int R = 8;

    typedef struct {
        int ai;
        int bi;
        int vi;
        int ratio;
        int clamped;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] v = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [R-1:0] ratio;
    logic         clamped;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    inv_lerp #(.INPUT_BITS(W), .RATIO_FRAC_BITS(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .v         (v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ratio     (ratio),
        .clamped   (clamped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: direct classification plus floor(|num|*2^r/|den|).
    function automatic void model(input int ai, input int bi, input int vi,
                                  output int r, output int c);
        longint num, den, an, ad;
        num = longint'(vi) - ai;
        den = longint'(bi) - ai;
        an  = (num < 0) ? -num : num;
        ad  = (den < 0) ? -den : den;
        if (den == 0)                 begin r = 0;   c = 1; end
        else if (num == 0)            begin r = 0;   c = 0; end
        else if ((num < 0) != (den < 0)) begin r = 0; c = 1; end
        else if (an >= ad)            begin r = 255; c = 1; end
        else begin r = int'((an * 256) / ad); c = 0; end
    endfunction

    // a + floor((b-a)*ratio/2^r) must not pass v.
    function automatic int roundtrip_ok(input int ai, input int bi, input int vi, input int r);
        longint p, fl, l;
        p  = (longint'(bi) - ai) * r;
        fl = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
        l  = ai + fl;
        if (bi > ai) return (l <= vi) ? 1 : 0;
        return (l >= vi) ? 1 : 0;
    endfunction

    task automatic do_req(input int ai, input int bi, input int vi, input int hold);
        exp_t e;
        int   lat;
        int   w;
        int   held_r;
        int   held_c;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_idle", in_ready, 1);
        out_ready = (hold == 0);
        a = W'(ai); b = W'(bi); v = W'(vi);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.ai = ai; e.bi = bi; e.vi = vi;
        model(ai, bi, vi, e.ratio, e.clamped);
        sb_q.push_back(e);
        // Operands after the accept edge must be ignored.
        a = W'($urandom); b = W'($urandom); v = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) check("in_ready_busy", in_ready, 0);
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, R);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        if (!out_valid) return;
        check("ratio", ratio, e.ratio);
        check("clamped", clamped, e.clamped);
        if (e.clamped == 0) check("roundtrip", roundtrip_ok(ai, bi, vi, int'(ratio)), 1);
        $display("txn a=%0d b=%0d v=%0d ratio=0x%02h clamped=%0d lat=%0d",
                 ai, bi, vi, ratio, clamped, lat);
        held_r = int'(ratio);
        held_c = int'(clamped);
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom); v = W'($urandom);
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_ratio", ratio, held_r);
            check("bp_clamped", clamped, held_c);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int ai, bi, vi, mode, hold;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_ratio", ratio, 0);
        check("rst_clamped", clamped, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // Directed classes
        do_req(0, 256, 128, 0);
        do_req(1000, 0, 750, 0);
        do_req(0, 65535, 65534, 0);
        do_req(500, 500, 500, 0);
        do_req(100, 200, 10, 0);
        do_req(100, 200, 200, 0);
        do_req(100, 200, 100, 0);
        do_req(0, 4, 3, 5);

        // Reset at the 4th DIVIDE edge aborts the request
        a = 16'd0; b = 16'd256; v = 16'd128; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_ratio", ratio, 0);
        check("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) check("abort_no_output", out_valid, 0);
        end
        $display("txn reset abort mid-divide");
        do_req(0, 4, 1, 0);

        // Random requests
        for (int n = 0; n < 3000; n++) begin
            mode = $urandom_range(0, 3);
            ai = $urandom_range(0, 65535);
            bi = $urandom_range(0, 65535);
            vi = $urandom_range(0, 65535);
            if (mode == 1) vi = $urandom_range(ai, bi);
            if (mode == 2) begin
                ai = $urandom_range(0, 15);
                bi = $urandom_range(0, 15);
                vi = $urandom_range(0, 15);
            end
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            do_req(ai, bi, vi, hold);
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
